// File: rtl/debounce_sync_stage.sv
// ---------------------------------------------------------------------------
// debounce_sync_stage
//
// Conditions a raw asynchronous level before it drives the data input of the
// delay-2 NOT-gate stage. The block:
//   - brings din into the clock domain through a two-flop synchroniser,
//   - ignores any change that does not hold for STABLE_CYCLES clocks,
//   - shows the clean level on dout, with one-cycle rise/fall strobes,
//   - counts rejected pulses in a saturating counter.
//
// Parameters
//   STABLE_CYCLES : number of clocks the synchronised input must hold a new
//                   value before dout follows it (must be >= 1)
//   GLITCH_W      : width of the rejected-glitch counter
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   din        : raw asynchronous level input
//   dout       : debounced level, feeds the NOT-gate stage
//   rise       : one-cycle strobe, asserted together with a dout 0->1 change
//   fall       : one-cycle strobe, asserted together with a dout 1->0 change
//   busy       : high while a pending transition is being qualified
//   glitch_cnt : saturating count of rejected pulses
// ---------------------------------------------------------------------------
module debounce_sync_stage #(
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  output logic                dout,
  output logic                rise,
  output logic                fall,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  // Value of cnt on the cycle a pending transition commits. For
  // STABLE_CYCLES = 1 this is 0, while a pending state is entered with cnt = 1;
  // the ">=" test below makes that case commit on the first evaluation.
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  typedef enum logic [1:0] {
    IDLE_LO,
    PEND_HI,
    IDLE_HI,
    PEND_LO
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser. Only s2 is used downstream, so s1 has a full
  // cycle to settle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Qualification FSM. All outputs are registered here. Each state is
  // checked for a reversal of s2 before it is checked for the commit
  // condition. As a result, a reversal on the same cycle cnt reaches its
  // final value is treated as a glitch. Reset drops any pending
  // qualification and does not count it as a glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE_LO;
      cnt        <= '0;
      dout       <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      busy       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LO: begin
          if (s2) begin
            state <= PEND_HI;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        PEND_HI: begin
          if (!s2) begin
            state <= IDLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
            if (glitch_cnt != GLITCH_MAX) begin
              glitch_cnt <= glitch_cnt + 1'b1;
            end
          end else if (cnt >= CNT_LAST) begin
            state <= IDLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
            dout  <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE_HI: begin
          if (!s2) begin
            state <= PEND_LO;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        PEND_LO: begin
          if (s2) begin
            state <= IDLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
            if (glitch_cnt != GLITCH_MAX) begin
              glitch_cnt <= glitch_cnt + 1'b1;
            end
          end else if (cnt >= CNT_LAST) begin
            state <= IDLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
            dout  <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE_LO;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_sync_stage.sv
// ---------------------------------------------------------------------------
// tb_debounce_sync_stage
//
// Self-checking bench for debounce_sync_stage. It uses two instances:
//   dut     : default parameters (STABLE_CYCLES = 4, GLITCH_W = 8)
//   dut_sat : GLITCH_W = 2, used to exercise counter saturation
// Expected values come from a vector table, from hand-written sequences, and
// from a run-length reference model driven with random stimulus.
// ---------------------------------------------------------------------------
module tb_debounce_sync_stage;

  localparam int STABLE = 4;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       dout;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] glitch_cnt;

  logic       din_sat;
  logic       dout_sat;
  logic       rise_sat;
  logic       fall_sat;
  logic       busy_sat;
  logic [1:0] glitch_sat;

  int checks;
  int errors;

  debounce_sync_stage #(.STABLE_CYCLES(STABLE), .GLITCH_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .busy       (busy),
    .glitch_cnt (glitch_cnt)
  );

  debounce_sync_stage #(.STABLE_CYCLES(STABLE), .GLITCH_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din_sat),
    .dout       (dout_sat),
    .rise       (rise_sat),
    .fall       (fall_sat),
    .busy       (busy_sat),
    .glitch_cnt (glitch_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst_n;
    logic din;
    logic dout;
    logic rise;
    logic fall;
    logic busy;
    int   glitch;
  } vec_t;

  vec_t vecs[$];

  // Reference model. It keeps a two-entry sample history standing in for the
  // synchroniser, plus the length of the current run of synchronised samples
  // that differ from the committed level. A run of STABLE such samples
  // commits the new level. A run broken early counts as one glitch.
  logic hist[2];
  logic m_dout;
  logic m_rise;
  logic m_fall;
  int   m_run;
  int   m_glitch;

  // Applies one set of inputs, then advances one rising edge and leaves
  // time 1 past the edge so outputs are read away from it.
  task automatic applyStimulus(input logic r, input logic d);
    rst_n = r;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  // Compares all five outputs of the main instance as one check.
  task automatic checkOutput(input string name, input logic e_dout, input logic e_rise,
                             input logic e_fall, input logic e_busy, input int e_glitch);
    checks++;
    if (dout !== e_dout || rise !== e_rise || fall !== e_fall || busy !== e_busy ||
        int'(glitch_cnt) != e_glitch) begin
      errors++;
      $display("[TB] FAIL %s: got dout=%b rise=%b fall=%b busy=%b glitch=%0d, want dout=%b rise=%b fall=%b busy=%b glitch=%0d",
               name, dout, rise, fall, busy, glitch_cnt, e_dout, e_rise, e_fall, e_busy, e_glitch);
    end
  endtask

  task automatic modelStep(input logic r, input logic d);
    logic seen;
    if (!r) begin
      hist[0]  = 1'b0;
      hist[1]  = 1'b0;
      m_dout   = 1'b0;
      m_rise   = 1'b0;
      m_fall   = 1'b0;
      m_run    = 0;
      m_glitch = 0;
    end else begin
      seen    = hist[1];
      hist[1] = hist[0];
      hist[0] = d;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      if (seen != m_dout) begin
        m_run++;
        if (m_run >= STABLE) begin
          m_dout = seen;
          m_rise = seen;
          m_fall = !seen;
          m_run  = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
  endtask

  function automatic vec_t mk(logic r, logic d, logic o, logic ri, logic fa, logic bu, int g);
    vec_t v;
    v.rst_n = r; v.din = d; v.dout = o; v.rise = ri; v.fall = fa; v.busy = bu; v.glitch = g;
    return v;
  endfunction

  initial begin
    int sat_exp[5];
    int hold;
    logic rd;

    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    din     = 1'b0;
    din_sat = 1'b0;

    // Reset held for 3 edges with din = 1, then a clean rise.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));  // edge 1
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));  // edge 2
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0));  // edge 3
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0));  // edge 4
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0));  // edge 5
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0));  // edge 6
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0));  // edge 7
    // Reset again, then a 2-cycle glitch.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1));
    // Clean rise, then a clean fall from dout = 1.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].din);
      checkOutput($sformatf("vec%0d", i), vecs[i].dout, vecs[i].rise, vecs[i].fall,
                  vecs[i].busy, vecs[i].glitch);
    end

    // Reset mid-pending: din rises, reset lands on edge 4, then din stays 1.
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(1, 0);
    applyStimulus(1, 1);
    applyStimulus(1, 1);
    applyStimulus(1, 1);
    checkOutput("midpend_busy", 0, 0, 0, 1, 0);
    applyStimulus(0, 1);
    checkOutput("midpend_reset", 0, 0, 0, 0, 0);
    for (int e = 1; e <= 6; e++) begin
      applyStimulus(1, 1);
      if (e < 3)       checkOutput($sformatf("midpend_e%0d", e), 0, 0, 0, 0, 0);
      else if (e < 6)  checkOutput($sformatf("midpend_e%0d", e), 0, 0, 0, 1, 0);
      else             checkOutput("midpend_e6", 1, 1, 0, 0, 0);
    end

    // Saturation on the 2-bit counter: five single-cycle pulses.
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(1, 0);
    sat_exp = '{1, 2, 3, 3, 3};
    for (int p = 0; p < 5; p++) begin
      din_sat = 1'b1;
      applyStimulus(1, 0);
      din_sat = 1'b0;
      for (int k = 0; k < 5; k++) applyStimulus(1, 0);
      checks++;
      if (int'(glitch_sat) != sat_exp[p] || dout_sat !== 1'b0 || busy_sat !== 1'b0 ||
          rise_sat !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sat_pulse%0d: got glitch=%0d dout=%b busy=%b rise=%b, want glitch=%0d dout=0 busy=0 rise=0",
                 p, glitch_sat, dout_sat, busy_sat, rise_sat, sat_exp[p]);
      end
    end

    // Random stimulus against the reference model.
    applyStimulus(0, 0);
    modelStep(0, 0);
    applyStimulus(0, 0);
    modelStep(0, 0);
    hold = 0;
    rd   = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic r;
      if (hold == 0) begin
        rd   = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 7));
      end
      hold--;
      r = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      applyStimulus(r, rd);
      modelStep(r, rd);
      checkOutput($sformatf("rand%0d", c), m_dout, m_rise, m_fall, m_run > 0, m_glitch);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
